// File: rtl/csd_pkg.sv
// Shared constellation-scrambler definitions: LFSR seed/step and quadrant rotation codes.
// Used by both the TX scrambler and the RX descrambler so the two stay in lock-step.
package csd_pkg;

  localparam logic [0:12] LFSR_SEED = 13'h1FFF;

  // Codes are the LFSR bit pair {L0, L1} with L0 as the MSB.
  typedef enum logic [1:0] {
    ID    = 2'b00,
    NEG_J = 2'b10,
    NEG   = 2'b01,
    POS_J = 2'b11
  } rot_sel_t;

  typedef enum logic {IDLE, RUN} csd_state_t;

  function automatic logic [0:12] lfsr_next(input logic [0:12] l);
    logic fbk1, fbk2;
    fbk1 = l[7] ^ l[10] ^ l[11] ^ l[12];
    fbk2 = l[6] ^ l[9] ^ l[10] ^ l[11];
    return {fbk2, fbk1, l[0:10]};
  endfunction

endpackage

// File: rtl/csd_rx_if.sv
// Sample stream into and out of the descrambler, plus the symbol-length error pulse.
interface csd_rx_if #(parameter int DW = 12);
  logic signed [DW-1:0] di_re, di_im;
  logic                 di_frame_start, di_sym_end, di_vld, di_rdy;
  logic signed [DW-1:0] do_re, do_im;
  logic                 do_sym_end, do_vld, do_rdy;
  logic                 sym_len_err;

  modport master (
    output di_re, di_im, di_frame_start, di_sym_end, di_vld, do_rdy,
    input  di_rdy, do_re, do_im, do_sym_end, do_vld, sym_len_err
  );

  modport slave (
    input  di_re, di_im, di_frame_start, di_sym_end, di_vld, do_rdy,
    output di_rdy, do_re, do_im, do_sym_end, do_vld, sym_len_err
  );
endinterface

// File: rtl/csd_skid_buf.sv
// Output register plus one skid entry; in_rdy is registered so upstream sees no comb path from out_rdy.
module csd_skid_buf #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  input  logic         out_rdy
);
  logic         out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, rdy_q, rdy_d;
  logic [W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic         in_fire, pop;

  always_comb begin
    in_fire     = in_vld & rdy_q;
    pop         = out_vld_q & out_rdy;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (!out_vld_q || pop) begin
      // rdy_q is low whenever the skid holds data, so in_fire cannot collide with a skid refill
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = skid_data_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = in_fire;
        if (in_fire) out_data_d = in_data;
      end
    end else if (in_fire) begin
      skid_vld_d  = 1'b1;
      skid_data_d = in_data;
    end
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      rdy_q       <= rdy_d;
    end
  end

  assign in_rdy   = rdy_q;
  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
endmodule

// File: rtl/csd_rx.sv
// RX constellation descrambler: undoes the per-subcarrier quadrant rotation from the TX LFSR,
// tracks frame/symbol boundaries and flags symbols whose length differs from NUM_SC.
module csd_rx
  import csd_pkg::*;
#(
  parameter int DW            = 12,
  parameter int NUM_SC        = 1024,
  parameter bit RESEED_ON_SYM = 1'b1
) (
  input  logic    payload_clk,
  input  logic    payload_rst_n,
  csd_rx_if.slave io
);
  localparam int            CW      = (NUM_SC > 1) ? $clog2(NUM_SC) : 1;
  localparam logic [CW-1:0] SC_LAST = CW'(NUM_SC - 1);
  localparam int            W       = 2 * DW + 1;

  csd_state_t           state_q, state_d;
  logic [0:12]          lfsr_q, lfsr_d, cur_lfsr;
  logic [CW-1:0]        sc_cnt_q, sc_cnt_d, sc_base;
  logic                 err_q, err_d;
  logic                 in_rdy, xfer, emit, out_vld;
  logic [W-1:0]         out_data;
  logic signed [DW-1:0] rot_re, rot_im, neg_re, neg_im;
  rot_sel_t             sel;

  assign xfer = io.di_vld & in_rdy;

  always_ff @(posedge payload_clk) begin
    if (!payload_rst_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (xfer && io.di_frame_start) state_d = RUN;
  end

  always_comb begin
    emit     = xfer && (state_q == RUN || io.di_frame_start);
    // frame_start samples are rotated with the seed, not with whatever the LFSR held
    cur_lfsr = io.di_frame_start ? LFSR_SEED : lfsr_q;
    sel      = rot_sel_t'(cur_lfsr[0:1]);
    neg_re   = -io.di_re;
    neg_im   = -io.di_im;
    rot_re   = io.di_re;
    rot_im   = io.di_im;
    unique case (sel)
      ID:    begin rot_re = io.di_re; rot_im = io.di_im; end
      NEG_J: begin rot_re = io.di_im; rot_im = neg_re;   end
      NEG:   begin rot_re = neg_re;   rot_im = neg_im;   end
      POS_J: begin rot_re = neg_im;   rot_im = io.di_re; end
    endcase

    lfsr_d   = lfsr_q;
    sc_cnt_d = sc_cnt_q;
    err_d    = 1'b0;
    sc_base  = io.di_frame_start ? '0 : sc_cnt_q;
    if (emit) begin
      err_d = (state_q == RUN) && io.di_frame_start && (sc_cnt_q != '0);
      if (io.di_sym_end) begin
        err_d    = err_d | (sc_base != SC_LAST);
        sc_cnt_d = '0;
      end else if (sc_base == SC_LAST) begin
        err_d    = 1'b1;
        sc_cnt_d = '0;
      end else begin
        sc_cnt_d = sc_base + 1'b1;
      end
      lfsr_d = (io.di_sym_end && RESEED_ON_SYM) ? LFSR_SEED : lfsr_next(cur_lfsr);
    end
  end

  always_ff @(posedge payload_clk) begin
    if (!payload_rst_n) begin
      lfsr_q   <= LFSR_SEED;
      sc_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      sc_cnt_q <= sc_cnt_d;
      err_q    <= err_d;
    end
  end

  csd_skid_buf #(.W(W)) u_skid (
    .clk      (payload_clk),
    .rst_n    (payload_rst_n),
    .in_vld   (emit),
    .in_data  ({io.di_sym_end, rot_re, rot_im}),
    .in_rdy   (in_rdy),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_rdy  (io.do_rdy)
  );

  assign io.di_rdy                         = in_rdy;
  assign io.do_vld                         = out_vld;
  assign {io.do_sym_end, io.do_re, io.do_im} = out_data;
  assign io.sym_len_err                    = err_q;
endmodule

// File: tb/tb_csd_rx.sv
// Random/directed bench for csd_rx: a TX-side reference scrambles random data, a scoreboard
// queue holds expected outputs and a negedge monitor checks them plus stall stability.
module tb_csd_rx;
  localparam int DW     = 12;
  localparam int NUM_SC = 16;
  localparam bit RESEED = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csd_rx_if #(.DW(DW)) ifc();

  csd_rx #(.DW(DW), .NUM_SC(NUM_SC), .RESEED_ON_SYM(RESEED)) dut (
    .payload_clk   (clk),
    .payload_rst_n (rst_n),
    .io            (ifc.slave)
  );

  typedef struct { int re; int im; bit se; } smp_t;
  smp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stall = 1'b0;

  // reference model state
  bit        m_run;
  bit [0:12] m_lfsr;
  int        m_cnt;
  int        orig_re[3*NUM_SC];
  int        orig_im[3*NUM_SC];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int wrap(input int v);
    logic signed [DW-1:0] t;
    t = v[DW-1:0];
    return int'(t);
  endfunction

  function automatic bit [0:12] adv(input bit [0:12] c);
    bit f1, f2;
    f1 = c[7] ^ c[10] ^ c[11] ^ c[12];
    f2 = c[6] ^ c[9] ^ c[10] ^ c[11];
    return {f2, f1, c[0:10]};
  endfunction

  // Number of quarter turns (multiply by j) the receiver applies for a given LFSR state.
  function automatic int quarter(input bit [0:12] c);
    case ({c[0], c[1]})
      2'b00:   return 0;
      2'b10:   return 3;
      2'b01:   return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int sel_q(input bit fs);
    return quarter(fs ? 13'h1FFF : m_lfsr);
  endfunction

  task automatic rot(input int re, input int im, input int q, output int ore, output int oim);
    int t;
    ore = re;
    oim = im;
    for (int i = 0; i < q; i++) begin
      t   = ore;
      ore = wrap(-oim);
      oim = t;
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_lfsr = 13'h1FFF;
    m_cnt  = 0;
  endtask

  task automatic model_xfer(input bit fs, input bit se, output bit emit, output int q, output bit err);
    bit [0:12] cur;
    int base;
    emit = 1'b0;
    err  = 1'b0;
    q    = 0;
    if (!m_run && !fs) return;
    emit = 1'b1;
    err  = m_run && fs && (m_cnt != 0);
    q    = sel_q(fs);
    cur  = fs ? 13'h1FFF : m_lfsr;
    base = fs ? 0 : m_cnt;
    if (se) begin
      if (base != NUM_SC - 1) err = 1'b1;
      m_cnt = 0;
    end else if (base == NUM_SC - 1) begin
      err   = 1'b1;
      m_cnt = 0;
    end else begin
      m_cnt = base + 1;
    end
    m_lfsr = (se && RESEED) ? 13'h1FFF : adv(cur);
    m_run  = 1'b1;
  endtask

  task automatic send(input int re, input int im, input bit fs, input bit se,
                      input bit ovr = 1'b0, input int ere = 0, input int eim = 0);
    bit   got, emit, err;
    int   q, ore, oim;
    smp_t e;
    got = 1'b0;
    ifc.di_re          = re[DW-1:0];
    ifc.di_im          = im[DW-1:0];
    ifc.di_frame_start = fs;
    ifc.di_sym_end     = se;
    ifc.di_vld         = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ifc.di_rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("send_timeout", 0, 1);
      ifc.di_vld = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model_xfer(fs, se, emit, q, err);
    if (emit) begin
      rot(re, im, q, ore, oim);
      e.re = ovr ? ere : ore;
      e.im = ovr ? eim : oim;
      e.se = se;
      exp_q.push_back(e);
    end
    chk("sym_len_err", int'(ifc.sym_len_err), int'(err));
    ifc.di_vld = 1'b0;
  endtask

  // TX side: rotate by the inverse quarter count, expect the original sample back.
  task automatic loopback(input int nsym);
    int q, sre, sim;
    bit fs, se;
    for (int s = 0; s < nsym; s++) begin
      for (int i = 0; i < NUM_SC; i++) begin
        int n;
        n  = s * NUM_SC + i;
        fs = (n == 0);
        se = (i == NUM_SC - 1);
        q  = sel_q(fs);
        rot(orig_re[n], orig_im[n], (4 - q) % 4, sre, sim);
        send(sre, sim, fs, se, 1'b1, orig_re[n], orig_im[n]);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    ifc.di_vld = 1'b0;
    rst_n      = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    exp_q.delete();
    model_reset();
    chk("rst_do_vld", int'(ifc.do_vld), 0);
    chk("rst_do_re", int'(ifc.do_re), 0);
    chk("rst_do_im", int'(ifc.do_im), 0);
    chk("rst_err", int'(ifc.sym_len_err), 0);
    chk("rst_di_rdy", int'(ifc.di_rdy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_di_rdy", int'(ifc.di_rdy), 1);
  endtask

  function automatic int first_sel01();
    bit [0:12] c;
    c = 13'h1FFF;
    for (int i = 0; i < NUM_SC - 1; i++) begin
      if (c[0] == 1'b0 && c[1] == 1'b1) return i;
      c = adv(c);
    end
    return -1;
  endfunction

  // downstream ready
  initial begin
    ifc.do_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ifc.do_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor / scoreboard
  bit             prev_stall = 1'b0;
  int             prev_re, prev_im, prev_se;
  initial begin
    smp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_vld", int'(ifc.do_vld), 1);
          chk("stall_re", int'(ifc.do_re), prev_re);
          chk("stall_im", int'(ifc.do_im), prev_im);
          chk("stall_se", int'(ifc.do_sym_end), prev_se);
        end
        if (ifc.do_vld && ifc.do_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_re", int'(ifc.do_re), e.re);
            chk("out_im", int'(ifc.do_im), e.im);
            chk("out_se", int'(ifc.do_sym_end), int'(e.se));
          end
        end
        prev_stall = ifc.do_vld && !ifc.do_rdy;
        prev_re    = int'(ifc.do_re);
        prev_im    = int'(ifc.do_im);
        prev_se    = int'(ifc.do_sym_end);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    ifc.di_vld         = 1'b0;
    ifc.di_re          = '0;
    ifc.di_im          = '0;
    ifc.di_frame_start = 1'b0;
    ifc.di_sym_end     = 1'b0;
    model_reset();
    for (int i = 0; i < 3 * NUM_SC; i++) begin
      orig_re[i] = int'($urandom_range(0, 4095)) - 2048;
      orig_im[i] = int'($urandom_range(0, 4095)) - 2048;
    end
    orig_re[5] = -2048;
    orig_im[9] = -2048;

    do_reset(3);

    // seed rotation then identity
    send(100, -50, 1'b1, 1'b0, 1'b1, 50, 100);
    send(7, 9, 1'b0, 1'b0, 1'b1, 7, 9);
    drain();

    // loopback, full throughput; first frame_start lands mid-symbol
    loopback(3);
    drain();

    // loopback under random backpressure
    stall = 1'b1;
    loopback(3);
    stall = 1'b0;
    drain();

    // short symbol, then seed rotation on the next sample
    for (int i = 0; i < 10; i++)
      send(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
           i == 0, i == 9);
    send(300, 200, 1'b0, 1'b0, 1'b1, -200, 300);
    drain();

    // nothing before frame_start; -(-2048) wraps
    do_reset(2);
    for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 4095)) - 2048, 11, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_vld", int'(ifc.do_vld), 0);
    k = first_sel01();
    chk("sel01_found", int'(k > 0), 1);
    for (int i = 0; i <= k; i++) begin
      if (i == k) send(-2048, 0, 1'b0, 1'b0, 1'b1, -2048, 0);
      else        send(int'($urandom_range(0, 4095)) - 2048, 5, i == 0, 1'b0);
    end
    drain();

    // reset mid-symbol, then LFSR restarts from the seed
    for (int i = 0; i < 6; i++) send(i * 13, -i, i == 0, 1'b0);
    do_reset(1);
    send(1, 2, 1'b0, 1'b0);
    send(3, 4, 1'b0, 1'b0);
    loopback(1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
